// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging the multicycle MIPS core to an Avalon-MM master port.
// Define MIPS_BUS_LSU_MISALIGN_TRAP_EN to fail misaligned requests without a bus cycle.
module mips_bus_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   address_reg;
  logic [BE_W-1:0]     byteenable_reg;
  logic [DATA_W-1:0]   writedata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                write_reg;
  logic                signed_reg;
  logic                err_reg;
  logic [1:0]          size_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [31:0]         wait_cnt_reg;

  logic [1:0]          size_eff;
  int                  acc_off, acc_n;
  logic [BE_W-1:0]     be_next;
  logic [DATA_W-1:0]   wd_next;
  logic                trap_next;
  logic                timeout_hit;

  int                  ld_off, ld_n;
  logic [DATA_W-1:0]   raw_val;
  logic [DATA_W-1:0]   load_val;
  logic                sign_bit;

  // Request-side lane steering: value byte (n-1-i) lands on lane off+i, wrap dropped.
  always_comb begin
    size_eff = (DATA_W == 32 && req_size == 2'd3) ? 2'd2 : req_size;
    acc_off  = int'(req_addr[OFF_W-1:0]);
    acc_n    = 1 << size_eff;
    be_next  = '0;
    wd_next  = '0;
    for (int k = 0; k < BE_W; k++) begin
      if (k >= acc_off && k < acc_off + acc_n) begin
        be_next[k] = 1'b1;
        for (int b = 0; b < BE_W; b++) begin
          if (req_write && b == acc_n - 1 - (k - acc_off))
            wd_next[8*k +: 8] = req_wdata[8*b +: 8];
        end
      end
    end
`ifdef MIPS_BUS_LSU_MISALIGN_TRAP_EN
    trap_next = (acc_off & (acc_n - 1)) != 0;
`else
    trap_next = 1'b0;
`endif
  end

  assign ld_off = int'(off_reg);
  assign ld_n   = 1 << size_reg;

  // Each result byte j pulls from lane off+n-1-j (big-endian reassembly).
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_load_lane
      logic [7:0] lane_byte;
      always_comb begin
        lane_byte = 8'h00;
        for (int k = 0; k < BE_W; k++) begin
          if (gi < ld_n && k == ld_off + ld_n - 1 - gi)
            lane_byte = readdata[8*k +: 8];
        end
      end
      assign raw_val[8*gi +: 8] = lane_byte;
    end
  endgenerate

  always_comb begin
    sign_bit = 1'b0;
    for (int s = 0; s <= OFF_W; s++) begin
      if (int'(size_reg) == s)
        sign_bit = raw_val[(8 << s) - 1];
    end
    load_val = raw_val;
    for (int j = 0; j < BE_W; j++) begin
      if (signed_reg && j >= ld_n)
        load_val[8*j +: 8] = {8{sign_bit}};
    end
  end

  assign timeout_hit = (WAIT_LIMIT > 0) && waitrequest &&
                       (wait_cnt_reg == 32'(WAIT_LIMIT - 1));

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = trap_next ? RESP : BUS;
      end
      BUS: begin
        read  = !write_reg;
        write = write_reg;
        if (!waitrequest || timeout_hit)
          state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      address_reg    <= '0;
      byteenable_reg <= '0;
      writedata_reg  <= '0;
      rdata_reg      <= '0;
      write_reg      <= 1'b0;
      signed_reg     <= 1'b0;
      err_reg        <= 1'b0;
      size_reg       <= 2'd0;
      off_reg        <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            address_reg    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            byteenable_reg <= be_next;
            writedata_reg  <= wd_next;
            write_reg      <= req_write;
            signed_reg     <= req_signed;
            size_reg       <= size_eff;
            off_reg        <= req_addr[OFF_W-1:0];
            wait_cnt_reg   <= '0;
            rdata_reg      <= '0;
            err_reg        <= trap_next;
          end
        end
        BUS: begin
          if (timeout_hit) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end else if (waitrequest) begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end else begin
            rdata_reg <= write_reg ? '0 : load_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign address    = address_reg;
  assign byteenable = byteenable_reg;
  assign writedata  = writedata_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg && (state_reg == RESP);

endmodule
